edge_event_arbiter: RTL and testbench
=====================================

// Module: edge_event_arbiter
// PURPOSE
//  Collects 1-cycle edge pulses from NUM_CH input conditioner instances (buttons/switches)
//  and serialises them into one event stream for a single consumer (e.g. the SPI/shift-register
//  control logic). Each channel has a one-deep event slot. A round-robin arbiter grants one slot
//  at a time over a valid/ready handshake. Events that arrive while their slot is full are dropped
//  and flagged as an overflow.
// PARAMETERS
//  NUM_CH   4  number of conditioned input channels (>=2)
//  CH_BITS  2  width of the channel index (>= clog2(NUM_CH))
// PORTS
//  clk             in   1        system clock; all logic is on posedge clk
//  reset           in   1        synchronous, active-high reset
//  posedge_in      in   NUM_CH   positiveedge pulses, one per channel
//  negedge_in      in   NUM_CH   negativeedge pulses, one per channel
//  event_valid     out  1        an event is presented on event_channel/event_rising
//  event_ready     in   1        consumer accepts the event when event_valid && event_ready
//  event_channel   out  CH_BITS  index of the presented channel
//  event_rising    out  1        1 = rising edge, 0 = falling edge
//  overflow        out  NUM_CH   sticky per-channel flag: an event was dropped
//  overflow_clear  in   1        clears all overflow bits
// BEHAVIOUR
//  Reset (clk edge with reset=1): every slot empty, ptr=NUM_CH-1, state=IDLE, event_valid=0,
//    event_channel=0, event_rising=0, overflow=0. Reset in mid-handshake drops the presented event.
//  Slot i capture, per cycle:
//    - posedge_in[i] (priority) or negedge_in[i] loads slot i as full, with type=rising/falling.
//    - A pulse while slot i is full and not being released this cycle: the pulse is dropped,
//      the slot keeps its old event, and overflow[i]<=1.
//    - A pulse in the same cycle the slot is released by the handshake: the new event is loaded,
//      with no overflow.
//    - posedge_in[i] and negedge_in[i] together: the rising event is stored and overflow[i]<=1.
//  overflow: sticky. overflow_clear clears it. A new overflow in the same cycle as the clear wins (bit=1).
//  FSM, 2 states:
//    IDLE: if any slot is full, grant the first full slot searching ptr+1, ptr+2, ... modulo NUM_CH.
//      Register event_channel and event_rising. event_valid<=1. Go to PRESENT.
//      If no slot is full, stay in IDLE with event_valid=0.
//    PRESENT: event_valid, event_channel and event_rising stay stable until the handshake.
//      On event_valid && event_ready: clear the granted slot, ptr<=granted index,
//      event_valid<=0, go to IDLE.
//    The granted slot cannot be overwritten while presented; it can only overflow.
//  Latency: pulse in cycle T -> slot full at T+1 -> event_valid=1 at T+2 (if the FSM is in IDLE).
//  Throughput: at most one event every 2 cycles (the IDLE cycle is always inserted).
//  Fairness: after a grant to channel k, channel k has the lowest priority. Any full slot is served
//    within NUM_CH grants. ptr wraps from NUM_CH-1 to 0.
//  event_ready with event_valid=0 is ignored.
//  Index arithmetic is modulo NUM_CH; NUM_CH need not be a power of two.
// TESTING
//  1 Reset: hold reset 2 cycles while driving pulses -> all outputs 0, and no event is shown after release.
//  2 Single event: posedge_in=4'b0100 at T, event_ready=1 -> event_valid=1 at T+2 with channel=2 and
//    rising=1, then event_valid=0 at T+3.
//  3 Round robin: pulse all 4 channels in one cycle, event_ready=1 -> grant order 0,1,2,3.
//    Then re-pulse ch0 and ch3 -> next grants 0 then 3.
//  4 Backpressure: event_ready=0 for 10 cycles on ch1 -> outputs stable. A second negedge_in[1]
//    pulse sets overflow=4'b0010 and the first (rising) event is still delivered.
//  5 Refill on release: negedge_in[0] in the same cycle as the ch0 handshake -> next event is ch0
//    falling, and overflow stays 0.
//  6 Overflow vs clear: overflow_clear in the same cycle as a new ch3 overflow -> overflow[3]=1.
//    A later clear alone gives 0.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Purpose : serialise per-channel 1-cycle edge pulses into one round-robin event stream.
// Latency : pulse at T -> slot full at T+1 -> event_valid at T+2 (when idle); max 1 event / 2 cycles.
// Backpr. : event held stable until event_valid && event_ready; pulses into a full slot are dropped
//           and set the sticky overflow bit for that channel.
// Ports   : clk, reset (sync, active-high); posedge_in/negedge_in [NUM_CH] edge pulses;
//           event_valid/event_ready handshake with event_channel/event_rising payload;
//           overflow [NUM_CH] sticky drop flags, overflow_clear clears them.
module edge_event_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_CH-1:0]  posedge_in,
  input  logic [NUM_CH-1:0]  negedge_in,
  output logic               event_valid,
  input  logic               event_ready,
  output logic [CH_BITS-1:0] event_channel,
  output logic               event_rising,
  output logic [NUM_CH-1:0]  overflow,
  input  logic               overflow_clear
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t             state_q, state_d;
  logic [NUM_CH-1:0]  slot_full_q, slot_full_d;
  logic [NUM_CH-1:0]  slot_rise_q, slot_rise_d;
  logic [NUM_CH-1:0]  overflow_q, overflow_d;
  logic [CH_BITS-1:0] ptr_q, ptr_d;
  logic [CH_BITS-1:0] chan_q, chan_d;
  logic               rise_q, rise_d;
  logic               valid_q, valid_d;

  logic               handshake;
  logic [NUM_CH-1:0]  slot_rel;
  logic [NUM_CH-1:0]  ovf_set;
  logic               gnt_found;
  logic [CH_BITS-1:0] gnt_idx;

  // Channel index ptr+k, modulo NUM_CH (NUM_CH need not be a power of two).
  function automatic logic [CH_BITS-1:0] rr_idx(input logic [CH_BITS-1:0] p, input int k);
    return CH_BITS'((int'(p) + k) % NUM_CH);
  endfunction

  assign handshake = valid_q && event_ready;

  always_comb begin
    slot_rel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      slot_rel[i] = handshake && (chan_q == CH_BITS'(i));
    end
  end

  // Slot capture. A slot being released this cycle may be refilled at once;
  // otherwise a full slot (including the one on display) drops the pulse.
  always_comb begin
    slot_full_d = slot_full_q;
    slot_rise_d = slot_rise_q;
    ovf_set     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (slot_rel[i]) slot_full_d[i] = 1'b0;
      if (posedge_in[i] || negedge_in[i]) begin
        if (slot_full_q[i] && !slot_rel[i]) begin
          ovf_set[i] = 1'b1;
        end else begin
          slot_full_d[i] = 1'b1;
          slot_rise_d[i] = posedge_in[i];
          // Simultaneous edges: keep the rising one, flag the lost falling one.
          if (posedge_in[i] && negedge_in[i]) ovf_set[i] = 1'b1;
        end
      end
    end
  end

  // New overflow wins over a same-cycle clear.
  assign overflow_d = (overflow_clear ? '0 : overflow_q) | ovf_set;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!gnt_found && slot_full_q[rr_idx(ptr_q, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    chan_d  = chan_q;
    rise_d  = rise_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          chan_d  = gnt_idx;
          rise_d  = slot_rise_q[gnt_idx];
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (handshake) begin
          ptr_d   = chan_q;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      slot_full_q <= '0;
      slot_rise_q <= '0;
      overflow_q  <= '0;
      ptr_q       <= CH_BITS'(NUM_CH - 1);
      chan_q      <= '0;
      rise_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_full_q <= slot_full_d;
      slot_rise_q <= slot_rise_d;
      overflow_q  <= overflow_d;
      ptr_q       <= ptr_d;
      chan_q      <= chan_d;
      rise_q      <= rise_d;
      valid_q     <= valid_d;
    end
  end

  assign event_valid   = valid_q;
  assign event_channel = chan_q;
  assign event_rising  = rise_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
module tb_edge_event_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] posedge_in;
  logic [3:0] negedge_in;
  logic       event_valid;
  logic       event_ready;
  logic [1:0] event_channel;
  logic       event_rising;
  logic [3:0] overflow;
  logic       overflow_clear;

  int n_tests = 0;
  int n_fail  = 0;

  edge_event_arbiter #(.NUM_CH(4), .CH_BITS(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .posedge_in     (posedge_in),
    .negedge_in     (negedge_in),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_channel  (event_channel),
    .event_rising   (event_rising),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset          = 1'b1;
    posedge_in     = 4'b1111;
    negedge_in     = 4'b0000;
    event_ready    = 1'b0;
    overflow_clear = 1'b0;

    // 1. Reset held two cycles with pulses active.
    tick();
    tick();
    check("rst_valid",   32'(event_valid),   32'd0);
    check("rst_channel", 32'(event_channel), 32'd0);
    check("rst_rising",  32'(event_rising),  32'd0);
    check("rst_ovf",     32'(overflow),      32'd0);
    reset      = 1'b0;
    posedge_in = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_event", 32'(event_valid), 32'd0);
    end

    // 2. Single event on ch2, ready high.
    posedge_in  = 4'b0100;
    event_ready = 1'b1;
    tick();
    posedge_in = 4'b0000;
    check("single_t1_valid", 32'(event_valid), 32'd0);
    tick();
    check("single_t2_valid", 32'(event_valid),   32'd1);
    check("single_t2_chan",  32'(event_channel), 32'd2);
    check("single_t2_rise",  32'(event_rising),  32'd1);
    tick();
    check("single_t3_valid", 32'(event_valid), 32'd0);

    // 3. Round robin from a fresh pointer (ptr=3 after reset).
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    posedge_in = 4'b1111;
    tick();
    posedge_in = 4'b0000;
    for (int g = 0; g < 4; g++) begin
      tick();
      check("rr_valid", 32'(event_valid),   32'd1);
      check("rr_chan",  32'(event_channel), 32'(g));
      tick();
      check("rr_gap",   32'(event_valid),   32'd0);
    end
    posedge_in = 4'b1001;
    tick();
    posedge_in = 4'b0000;
    tick();
    check("rr2_first_chan", 32'(event_channel), 32'd0);
    tick();
    tick();
    check("rr2_second_valid", 32'(event_valid),   32'd1);
    check("rr2_second_chan",  32'(event_channel), 32'd3);
    tick();

    // 4. Backpressure on ch1 with a dropped falling edge.
    event_ready = 1'b0;
    posedge_in  = 4'b0010;
    tick();
    posedge_in = 4'b0000;
    tick();
    for (int i = 0; i < 10; i++) begin
      negedge_in = (i == 3) ? 4'b0010 : 4'b0000;
      tick();
      check("bp_stable", {28'd0, event_valid, event_channel, event_rising}, {28'd0, 1'b1, 2'd1, 1'b1});
    end
    negedge_in = 4'b0000;
    check("bp_ovf", 32'(overflow), 32'h2);
    event_ready = 1'b1;
    tick();
    check("bp_done", 32'(event_valid), 32'd0);
    tick();
    check("bp_dropped_not_shown", 32'(event_valid), 32'd0);
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    check("bp_clear", 32'(overflow), 32'd0);

    // 5. Refill ch0 in the same cycle it is released.
    posedge_in = 4'b0001;
    tick();
    posedge_in = 4'b0000;
    tick();
    check("refill_first", {28'd0, event_valid, event_channel, event_rising}, {28'd0, 1'b1, 2'd0, 1'b1});
    negedge_in = 4'b0001;
    tick();
    negedge_in = 4'b0000;
    check("refill_release_valid", 32'(event_valid), 32'd0);
    check("refill_release_ovf",   32'(overflow),    32'd0);
    tick();
    check("refill_second", {28'd0, event_valid, event_channel, event_rising}, {28'd0, 1'b1, 2'd0, 1'b0});
    tick();
    check("refill_end_valid", 32'(event_valid), 32'd0);
    check("refill_end_ovf",   32'(overflow),    32'd0);

    // 6. Overflow on ch3 coincident with clear.
    event_ready = 1'b0;
    posedge_in  = 4'b1000;
    tick();
    posedge_in = 4'b0000;
    tick();
    check("oc_presented_chan", 32'(event_channel), 32'd3);
    posedge_in     = 4'b1000;
    overflow_clear = 1'b1;
    tick();
    posedge_in     = 4'b0000;
    overflow_clear = 1'b0;
    check("oc_set_wins", 32'(overflow), 32'h8);
    tick();
    check("oc_sticky", 32'(overflow), 32'h8);
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    check("oc_clear_alone", 32'(overflow), 32'd0);
    event_ready = 1'b1;
    tick();
    check("oc_done", 32'(event_valid), 32'd0);

    // 7. Simultaneous rising and falling pulse on ch2.
    posedge_in = 4'b0100;
    negedge_in = 4'b0100;
    tick();
    posedge_in = 4'b0000;
    negedge_in = 4'b0000;
    check("both_ovf", 32'(overflow), 32'h4);
    tick();
    check("both_event", {28'd0, event_valid, event_channel, event_rising}, {28'd0, 1'b1, 2'd2, 1'b1});
    tick();
    check("both_done", 32'(event_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
